// File: rtl/sg_bist_pkg.sv
//------------------------------------------------------------------------------
// Module   : sg_bist_pkg
// Purpose  : Shared definitions for the sg BIST controller: FSM state
//            encoding, LFSR/MISR tap mask, default LFSR seed, popcount helper.
// Ports    : none (package)
// Options  : SG_BIST_TOGGLE_CNT_EN (popcount helper is used only then)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sg_bist_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } sg_bist_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, left-shifting Fibonacci form:
  // feedback = s[15] ^ s[13] ^ s[12] ^ s[10]
  localparam logic [15:0] C_LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] C_DEFAULT_SEED = 16'hACE1;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sg_bist_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : sg_bist_ctrl_if
// Purpose  : Request/response bundle between a BIST requester / cell under
//            test and the sg BIST controller.
// Signals  : START, NVEC      - run request and vector count
//            STIM, RESP       - stimulus to / response from the cell
//            BUSY, DONE, SIG  - status and MISR signature
//            TCNT             - response toggle count (SG_BIST_TOGGLE_CNT_EN)
// Modports : master - requester side, slave - controller side
// Options  : SG_BIST_TOGGLE_CNT_EN adds TCNT
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sg_bist_ctrl_if #(
  parameter int STIM_W = 8,
  parameter int RESP_W = 8
);
  logic              START;
  logic [15:0]       NVEC;
  logic [STIM_W-1:0] STIM;
  logic [RESP_W-1:0] RESP;
  logic              BUSY;
  logic              DONE;
  logic [15:0]       SIG;
`ifdef SG_BIST_TOGGLE_CNT_EN
  logic [15:0]       TCNT;
`endif

`ifdef SG_BIST_TOGGLE_CNT_EN
  modport master (output START, NVEC, RESP, input STIM, BUSY, DONE, SIG, TCNT);
  modport slave  (input START, NVEC, RESP, output STIM, BUSY, DONE, SIG, TCNT);
`else
  modport master (output START, NVEC, RESP, input STIM, BUSY, DONE, SIG);
  modport slave  (input START, NVEC, RESP, output STIM, BUSY, DONE, SIG);
`endif
endinterface

`default_nettype wire

// File: rtl/sg_lfsr_step.sv
//------------------------------------------------------------------------------
// Module   : sg_lfsr_step
// Purpose  : Combinational one-step advance of a 16-bit left-shifting
//            Fibonacci LFSR; feedback (XOR of tapped bits) enters bit 0.
// Ports    : i_state - current register value
//            o_next  - value after one shift
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sg_lfsr_step
  import sg_bist_pkg::*;
#(
  parameter logic [15:0] TAPS = C_LFSR_TAPS
) (
  input  logic [15:0] i_state,
  output logic [15:0] o_next
);

  assign o_next = {i_state[14:0], ^(i_state & TAPS)};

endmodule

`default_nettype wire

// File: rtl/sg_bist_ctrl.sv
//------------------------------------------------------------------------------
// Module   : sg_bist_ctrl
// Purpose  : BIST controller for an sg cell. On START it drives NVEC
//            pseudo-random vectors from an LFSR, compacts the returned
//            responses (one cycle late) into a MISR and publishes the
//            signature on SIG with a one-cycle DONE pulse.
// Ports    : CP   - clock, rising edge
//            RST  - synchronous active-high reset
//            bus  - sg_bist_ctrl_if.slave (START, NVEC, RESP in;
//                   STIM, BUSY, DONE, SIG [, TCNT] out)
// Options  : SG_BIST_TOGGLE_CNT_EN - adds TCNT, a saturating count of RESP
//            bit toggles over the capture window
// Notes    : STIM_W up to 16 carries LFSR bits; wider buses are zero-padded.
//            RESP_W must not exceed 16.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sg_bist_ctrl
  import sg_bist_pkg::*;
#(
  parameter int          STIM_W = 8,
  parameter int          RESP_W = 8,
  parameter logic [15:0] SEED   = C_DEFAULT_SEED
) (
  input  logic           CP,
  input  logic           RST,
  sg_bist_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_FIN   = ST_FIN;

  logic [1:0]  r_state;
  logic [15:0] r_lfsr;
  logic [15:0] r_misr;
  logic [15:0] r_sig;
  logic [15:0] r_cnt;
  // High in every cycle that follows a RUN cycle: that is exactly when the
  // response to the previous vector is on RESP (RUN minus its first cycle,
  // plus DRAIN).
  logic        r_cap;

  logic [15:0] w_lfsr_nxt;
  logic [15:0] w_misr_step;
  logic [15:0] w_misr_nxt;
  logic [15:0] w_resp_ext;

  assign w_resp_ext = 16'(bus.RESP);
  assign w_misr_nxt = w_misr_step ^ w_resp_ext;

  sg_lfsr_step #(.TAPS(C_LFSR_TAPS)) u_lfsr_step (
    .i_state (r_lfsr),
    .o_next  (w_lfsr_nxt)
  );

  sg_lfsr_step #(.TAPS(C_LFSR_TAPS)) u_misr_step (
    .i_state (r_misr),
    .o_next  (w_misr_step)
  );

  always_ff @(posedge CP) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_misr  <= 16'd0;
      r_sig   <= 16'd0;
      r_cnt   <= 16'd0;
      r_cap   <= 1'b0;
    end else begin
      r_cap <= (r_state == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            r_lfsr  <= SEED;
            r_misr  <= 16'd0;
            r_sig   <= 16'd0;
            r_cnt   <= bus.NVEC;
            // A zero-length run skips straight to the completion pulse.
            r_state <= (bus.NVEC == 16'd0) ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          r_lfsr <= w_lfsr_nxt;
          r_cnt  <= r_cnt - 16'd1;
          if (r_cap) begin
            r_misr <= w_misr_nxt;
          end
          if (r_cnt == 16'd1) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Last response arrives here; fold it and publish in one step.
          r_misr  <= w_misr_nxt;
          r_sig   <= w_misr_nxt;
          r_state <= S_FIN;
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.STIM = (r_state == S_RUN) ? STIM_W'(r_lfsr) : '0;
  assign bus.BUSY = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.DONE = (r_state == S_FIN);
  assign bus.SIG  = r_sig;

`ifdef SG_BIST_TOGGLE_CNT_EN
  logic [15:0] r_resp_prev;
  logic [15:0] r_tcnt;
  logic [4:0]  w_tog;
  logic [16:0] w_tsum;

  assign w_tog  = popcount16(w_resp_ext ^ r_resp_prev);
  assign w_tsum = {1'b0, r_tcnt} + 17'(w_tog);

  always_ff @(posedge CP) begin
    if (RST) begin
      r_resp_prev <= 16'd0;
      r_tcnt      <= 16'd0;
    end else begin
      r_resp_prev <= w_resp_ext;
      if ((r_state == S_IDLE) && bus.START) begin
        r_tcnt <= 16'd0;
      end else if (r_cap) begin
        r_tcnt <= w_tsum[16] ? 16'hFFFF : w_tsum[15:0];
      end
    end
  end

  assign bus.TCNT = r_tcnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sg_bist_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_sg_bist_ctrl
// Purpose  : Self-checking bench for sg_bist_ctrl. A behavioural model
//            computes vector streams, signatures, BUSY/DONE timing and toggle
//            counts from the LFSR/MISR rules; directed and random runs.
// Options  : SG_BIST_TOGGLE_CNT_EN enables TCNT checks
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sg_bist_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic CP;
  logic RST;
  int   n_chk;
  int   n_fail;
  logic [7:0] resp_tab [0:31];

  sg_bist_ctrl_if #(.STIM_W(8), .RESP_W(8)) bus ();

  sg_bist_ctrl #(.STIM_W(8), .RESP_W(8), .SEED(SEED)) dut (
    .CP  (CP),
    .RST (RST),
    .bus (bus)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  // One complete run starting from an IDLE observation point; returns at the
  // IDLE observation after FIN so a following call starts back-to-back.
  task automatic run(input int n, input bit glitch);
    logic [15:0] l;
    logic [15:0] m;
    logic [7:0]  prev;
    int          tog;
    int          busy_cnt;
    int          last;
    l = SEED;
    m = 16'd0;
    prev = 8'd0;
    tog = 0;
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      m = lfsr_adv(m) ^ {8'd0, resp_tab[i]};
      tog += $countones(resp_tab[i] ^ prev);
      prev = resp_tab[i];
    end
    if (tog > 65535) tog = 65535;
    last = (n == 0) ? 2 : n + 3;

    bus.START = 1'b1;
    bus.NVEC  = 16'(n);
    bus.RESP  = 8'd0;
    for (int c = 1; c <= last; c++) begin
      tick();
      bus.START = 1'b0;
      if (bus.BUSY === 1'b1) busy_cnt++;
      if (n == 0) begin
        chk("z_done", {31'd0, bus.DONE}, (c == 1) ? 32'd1 : 32'd0);
        chk("z_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("z_sig", {16'd0, bus.SIG}, 32'd0);
      end else if (c <= n) begin
        chk("run_stim", {24'd0, bus.STIM}, {24'd0, l[7:0]});
        chk("run_busy", {31'd0, bus.BUSY}, 32'd1);
        chk("run_done", {31'd0, bus.DONE}, 32'd0);
        l = lfsr_adv(l);
      end else if (c == n + 1) begin
        chk("drain_busy", {31'd0, bus.BUSY}, 32'd1);
        chk("drain_stim", {24'd0, bus.STIM}, 32'd0);
        chk("drain_done", {31'd0, bus.DONE}, 32'd0);
      end else if (c == n + 2) begin
        chk("fin_done", {31'd0, bus.DONE}, 32'd1);
        chk("fin_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("fin_sig", {16'd0, bus.SIG}, {16'd0, m});
`ifdef SG_BIST_TOGGLE_CNT_EN
        chk("fin_tcnt", {16'd0, bus.TCNT}, 32'(tog));
`endif
      end else begin
        chk("idle_done", {31'd0, bus.DONE}, 32'd0);
        chk("idle_stim", {24'd0, bus.STIM}, 32'd0);
        chk("idle_sig_hold", {16'd0, bus.SIG}, {16'd0, m});
      end
      // Response to the vector of cycle c-1 is presented during cycle c.
      if (n > 0 && c >= 2 && c <= n + 1) bus.RESP = resp_tab[c-2];
      else bus.RESP = 8'd0;
      // A START during RUN must be ignored.
      if (glitch && c == 2) begin
        bus.START = 1'b1;
        bus.NVEC  = 16'd3;
      end
    end
    chk("busy_cycles", 32'(busy_cnt), (n == 0) ? 32'd0 : 32'(n + 1));
  endtask

  initial begin
    int done_seen;
    n_chk  = 0;
    n_fail = 0;
    RST = 1'b1;
    bus.START = 1'b0;
    bus.NVEC  = 16'd0;
    bus.RESP  = 8'd0;
    for (int i = 0; i < 32; i++) resp_tab[i] = 8'd0;

    // Reset state
    tick();
    tick();
    chk("rst_stim", {24'd0, bus.STIM}, 32'd0);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_done", {31'd0, bus.DONE}, 32'd0);
    chk("rst_sig", {16'd0, bus.SIG}, 32'd0);
    RST = 1'b0;
    tick();

    // NVEC=4 with RESP tied to 0
    run(4, 1'b0);
    chk("n4_sig_zero", {16'd0, bus.SIG}, 32'd0);

    // NVEC=1 with single response 8'h01
    resp_tab[0] = 8'h01;
    run(1, 1'b0);
    chk("n1_sig", {16'd0, bus.SIG}, 32'h0001);

    // NVEC=0
    run(0, 1'b0);

    // START pulsed during RUN
    for (int i = 0; i < 32; i++) resp_tab[i] = 8'($urandom_range(0, 255));
    run(7, 1'b1);

    // Random back-to-back runs
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) resp_tab[i] = 8'($urandom_range(0, 255));
      run(int'($urandom_range(1, 20)), 1'b0);
    end

`ifdef SG_BIST_TOGGLE_CNT_EN
    resp_tab[0] = 8'hFF;
    resp_tab[1] = 8'h00;
    run(2, 1'b0);
`endif

    // RST mid-run aborts without DONE
    bus.START = 1'b1;
    bus.NVEC  = 16'd8;
    tick();
    bus.START = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("abort_stim", {24'd0, bus.STIM}, 32'd0);
    chk("abort_done", {31'd0, bus.DONE}, 32'd0);
    chk("abort_sig", {16'd0, bus.SIG}, 32'd0);
    done_seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);

    // RST wins over START in the same cycle
    RST = 1'b1;
    bus.START = 1'b1;
    bus.NVEC  = 16'd3;
    tick();
    RST = 1'b0;
    bus.START = 1'b0;
    chk("prio_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("prio_done", {31'd0, bus.DONE}, 32'd0);
    tick();
    chk("prio_idle_busy", {31'd0, bus.BUSY}, 32'd0);

    // Controller still usable afterwards
    for (int i = 0; i < 32; i++) resp_tab[i] = 8'($urandom_range(0, 255));
    run(5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sg_bist_ctrl.md
SG_BIST_CTRL -- requirements
Module: sg_bist_ctrl

Interface
REQ-001 SHALL have parameter STIM_W, default 8, width of the stimulus bus driven into the sg cell under test.
REQ-002 SHALL have parameter RESP_W, default 8 (RESP_W <= 16), width of the response bus returned from the cell under test.
REQ-003 SHALL have parameter SEED, default 16'hACE1, the LFSR start value, which is never zero.
REQ-004 SHALL have port CP, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port START, input, 1 bit: request a test run, sampled in IDLE only.
REQ-007 SHALL have port NVEC, input, 16 bits: number of vectors, sampled with START.
REQ-008 SHALL have port STIM, output, STIM_W bits: vector driven to the cell under test.
REQ-009 SHALL have port RESP, input, RESP_W bits: cell response, valid one cycle after the matching STIM.
REQ-010 SHALL have port BUSY, output, 1 bit: high in RUN and DRAIN.
REQ-011 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port SIG, output, 16 bits: MISR signature, held stable from DONE until the next START.

Function
REQ-013 SHALL implement the FSM IDLE -> RUN -> DRAIN -> FIN -> IDLE.
REQ-014 SHALL treat START sampled high in IDLE at edge k as follows: latch NVEC, load LFSR=SEED, clear MISR=0, and enter RUN at k+1.
REQ-015 SHALL, in RUN, drive STIM = LFSR[STIM_W-1:0] and advance the LFSR every cycle, for exactly NVEC cycles (cycles k+1..k+NVEC).
REQ-016 SHALL use a Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1, shifting left with the feedback bit into bit 0.
REQ-017 SHALL update the MISR as misr <= step(misr) ^ zero_extend(RESP), where step() is the same polynomial, on cycles k+2..k+NVEC+1.
REQ-018 SHALL spend one cycle in DRAIN to capture the final response, then one cycle in FIN with DONE=1 and BUSY=0, then return to IDLE.
REQ-019 SHALL treat NVEC=0 with START as a jump directly to FIN at k+1, leaving SIG=0 and never asserting BUSY.
REQ-020 SHALL ignore START outside IDLE.
REQ-021 SHALL accept START asserted in the IDLE cycle right after FIN as a new run.
REQ-022 SHALL drive STIM to 0 outside RUN.
REQ-023 SHALL load SIG from the MISR on the DRAIN->FIN edge.

Reset
REQ-024 SHALL, on RST=1 at a CP edge, force: state IDLE, STIM=0, BUSY=0, DONE=0, SIG=0, LFSR=SEED, MISR=0, vector counter=0.
REQ-025 SHALL, on RST mid-run, abort the run with no DONE pulse and no SIG update.
REQ-026 SHALL give RST priority over START in the same cycle.

Configuration
REQ-027 SHALL, with SG_BIST_TOGGLE_CNT_EN defined, add output TCNT (16 bits) counting RESP bit toggles (popcount of RESP ^ previous RESP) over the capture window, saturating at 16'hFFFF, cleared on START and RST, and valid at DONE.
REQ-028 SHALL, without SG_BIST_TOGGLE_CNT_EN, have neither the TCNT port nor its logic, with all other behaviour unchanged.

Structure
REQ-029 SHALL place the shared package sg_bist_pkg, holding the FSM state enum, the LFSR tap constant, and the default SEED.
REQ-030 SHALL instantiate sub-module sg_lfsr_step (combinational next-state function) twice: once for the LFSR and once for the MISR.

Verification
REQ-031 SHALL cover: reset, then START with NVEC=4 and RESP tied to 0 -> STIM=8'hE1 in the first RUN cycle, BUSY high for 5 cycles, DONE at k+6, SIG=16'h0000.
REQ-032 SHALL cover: NVEC=1 with RESP=8'h01 at k+2 -> SIG=16'h0001, DONE at k+3.
REQ-033 SHALL cover: NVEC=0 -> DONE at k+1, BUSY never high, SIG=0.
REQ-034 SHALL cover: RST asserted at k+2 of an NVEC=8 run -> next cycle IDLE, STIM=0, BUSY=0, and no DONE afterwards.
REQ-035 SHALL cover: START pulsed during RUN -> ignored, and the run length still equals the original NVEC.
REQ-036 SHALL cover, with SG_BIST_TOGGLE_CNT_EN: NVEC=2 with RESP=8'hFF then 8'h00 -> TCNT=16 at DONE.
